// File: rtl/rover_led_driver_pkg.sv
// rover_led_pkg: constants shared by the rover LED driver blocks.
//   - Register addresses of the LED driver's Avalon-MM slave
//   - CTRL bit positions
//   - Reset values of the configuration registers
package rover_led_pkg;

  // Register map
  localparam logic [1:0] ADDR_CTRL       = 2'd0;
  localparam logic [1:0] ADDR_BRIGHT     = 2'd1;
  localparam logic [1:0] ADDR_BLINK_HALF = 2'd2;
  localparam logic [1:0] ADDR_STATUS     = 2'd3;

  // CTRL bit positions
  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_BLINK_EN_BIT = 1;

  // STATUS field positions
  localparam int STATUS_PHASE_BIT   = 0;
  localparam int STATUS_PATTERN_LSB = 8;

  // Reset values
  localparam logic       CTRL_ENABLE_RST   = 1'b1;
  localparam logic       CTRL_BLINK_EN_RST = 1'b0;
  localparam logic [7:0] BRIGHT_RST        = 8'hFF;

  // PWM counter runs 0..PWM_LAST, giving a 255-cycle period so that
  // BRIGHT=N lights the LEDs for exactly N of every 255 cycles.
  localparam logic [7:0] PWM_LAST   = 8'd254;
  localparam logic [7:0] BRIGHT_MAX = 8'hFF;

endpackage

// File: rtl/rover_led_driver_if.sv
// rover_led_driver_if: zero-wait-state Avalon-MM slave bus of the LED driver.
//   address    : register select
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : read data, combinational from address
interface rover_led_driver_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/rover_led_driver_tick_prescaler.sv
// rover_tick_prescaler: divide-by-TICK_DIV counter.
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   tick  : 1-cycle pulse, high in the cycle whose edge wraps the counter
module rover_tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int              CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  assign tick     = (cnt_reg == CNT_LAST);
  assign cnt_next = tick ? '0 : cnt_reg + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_reg <= '0;
    else       cnt_reg <= cnt_next;
  end
endmodule

// File: rtl/rover_led_driver.sv
// rover_led_driver: drives the LED pins from the PIO pattern with global
// brightness PWM and optional blinking, configured over an Avalon-MM slave.
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   bus        : register slave (CTRL, BRIGHT, BLINK_HALF, STATUS)
//   pattern_in : LED pattern from the PIO
//   led_out    : registered LED pin drive, 1 = lit
module rover_led_driver
  import rover_led_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int TICK_DIV  = 50000,
  parameter int BLINK_RST = 500
) (
  input  logic                 clk,
  input  logic                 reset,
  rover_led_driver_if.slave    bus,
  input  logic [WIDTH-1:0]     pattern_in,
  output logic [WIDTH-1:0]     led_out
);

  logic             enable_reg;
  logic             blink_en_reg;
  logic [7:0]       bright_reg;
  logic [15:0]      blink_half_reg;
  logic [WIDTH-1:0] pattern_q_reg;
  logic [7:0]       pwm_cnt_reg;
  logic [7:0]       pwm_cnt_next;
  logic             phase_reg;
  logic             phase_next;
  logic [15:0]      blink_cnt_reg;
  logic [15:0]      blink_cnt_next;
  logic [WIDTH-1:0] led_next;

  logic tick;
  logic wr_en, wr_ctrl, wr_bright, wr_half;
  logic blink_restart, blink_active, blink_wrap;
  logic pwm_on, show;

  rover_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign wr_en     = bus.chipselect && !bus.write_n;
  assign wr_ctrl   = wr_en && (bus.address == ADDR_CTRL);
  assign wr_bright = wr_en && (bus.address == ADDR_BRIGHT);
  assign wr_half   = wr_en && (bus.address == ADDR_BLINK_HALF);

  // A new half-period, or switching blink on, restarts the blink from the
  // lit phase; this takes priority over a tick in the same cycle so a
  // shrunken BLINK_HALF can never leave the counter past its compare value.
  assign blink_restart = wr_half ||
                         (wr_ctrl && bus.writedata[CTRL_BLINK_EN_BIT] && !blink_en_reg);
  assign blink_active  = blink_en_reg && (blink_half_reg != 16'd0);
  assign blink_wrap    = (blink_cnt_reg == blink_half_reg - 16'd1);

  assign pwm_cnt_next = (pwm_cnt_reg == PWM_LAST) ? 8'd0 : pwm_cnt_reg + 8'd1;
  // BRIGHT=0xFF would otherwise be off for none of the 255 counts anyway,
  // but forcing it keeps full brightness independent of the PWM period.
  assign pwm_on = (bright_reg == BRIGHT_MAX) || (pwm_cnt_reg < bright_reg);
  assign show   = enable_reg && phase_reg && pwm_on;

  always_comb begin
    phase_next     = phase_reg;
    blink_cnt_next = blink_cnt_reg;
    if (blink_restart || !blink_active) begin
      phase_next     = 1'b1;
      blink_cnt_next = 16'd0;
    end else if (tick) begin
      if (blink_wrap) begin
        phase_next     = ~phase_reg;
        blink_cnt_next = 16'd0;
      end else begin
        blink_cnt_next = blink_cnt_reg + 16'd1;
      end
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_led
    assign led_next[gi] = show & pattern_q_reg[gi];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_reg     <= CTRL_ENABLE_RST;
      blink_en_reg   <= CTRL_BLINK_EN_RST;
      bright_reg     <= BRIGHT_RST;
      blink_half_reg <= 16'(BLINK_RST);
      pattern_q_reg  <= '0;
      pwm_cnt_reg    <= 8'd0;
      phase_reg      <= 1'b1;
      blink_cnt_reg  <= 16'd0;
      led_out        <= '0;
    end else begin
      if (wr_ctrl) begin
        enable_reg   <= bus.writedata[CTRL_ENABLE_BIT];
        blink_en_reg <= bus.writedata[CTRL_BLINK_EN_BIT];
      end
      if (wr_bright) bright_reg     <= bus.writedata[7:0];
      if (wr_half)   blink_half_reg <= bus.writedata[15:0];
      pattern_q_reg <= pattern_in;
      pwm_cnt_reg   <= pwm_cnt_next;
      phase_reg     <= phase_next;
      blink_cnt_reg <= blink_cnt_next;
      led_out       <= led_next;
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_CTRL: begin
        bus.readdata[CTRL_ENABLE_BIT]   = enable_reg;
        bus.readdata[CTRL_BLINK_EN_BIT] = blink_en_reg;
      end
      ADDR_BRIGHT:     bus.readdata[7:0]  = bright_reg;
      ADDR_BLINK_HALF: bus.readdata[15:0] = blink_half_reg;
      default: begin
        bus.readdata[STATUS_PHASE_BIT]                 = phase_reg;
        bus.readdata[STATUS_PATTERN_LSB +: WIDTH]      = pattern_q_reg;
      end
    endcase
  end

endmodule
